// File: rtl/br_task_sched_if.sv
// Bundle between the execute/CDB resolution slots and the branch-stack task sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; the sequencer always accepts. Stalls are signalled via recovering.
interface br_task_sched_if #(
  parameter int DEPTH = 4,
  parameter int N     = 2
);
  // Resolutions from execute/CDB.
  logic [N-1:0]            res_valid;
  logic [N-1:0][DEPTH-1:0] res_b_id;
  logic [N-1:0][DEPTH-1:0] res_b_mask;
  logic [N-1:0]            res_mispred;

  // Task to the branch stack, plus status.
  logic [1:0]              br_task;
  logic [DEPTH-1:0]        rem_b_id;
  logic                    recovering;
  logic [DEPTH-1:0]        pending;

  // Producer of resolutions, consumer of tasks.
  modport master (
    output res_valid, res_b_id, res_b_mask, res_mispred,
    input  br_task, rem_b_id, recovering, pending
  );

  // The sequencer itself.
  modport slave (
    input  res_valid, res_b_id, res_b_mask, res_mispred,
    output br_task, rem_b_id, recovering, pending
  );
endinterface

// File: rtl/br_task_sched.sv
// Buffers up to N branch resolutions/cycle and issues one SQUASH/CLEAR task per cycle to the branch stack.
// Latency: >=1 cycle from res_valid to br_task (registered); each SQUASH is followed by RECOVER_CYC NOTHING cycles.
// Backpressure: none; one slot per b_id so the buffer never fills. Optional perf counters: BR_TASK_SCHED_PERF_EN.
module br_task_sched #(
  parameter int DEPTH       = 4,
  parameter int N           = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic           i_clock,
  input  logic           i_reset,     // active-low, asynchronous
  br_task_sched_if.slave io_sched
`ifdef BR_TASK_SCHED_PERF_EN
  ,
  output logic [31:0]    o_perf_squash_cnt,
  output logic [31:0]    o_perf_clear_cnt,
  output logic [31:0]    o_perf_recover_cyc
`endif
);

  localparam logic [1:0] BR_NOTHING = 2'd0;
  localparam logic [1:0] BR_CLEAR   = 2'd1;
  localparam logic [1:0] BR_SQUASH  = 2'd2;

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_RECOVER  = 1'b1;

  localparam int CW = (RECOVER_CYC < 2) ? 1 : $clog2(RECOVER_CYC + 1);

  // Slot state, indexed by b_id bit position.
  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0]            r_mis;
  logic [DEPTH-1:0][DEPTH-1:0] r_mask;

  // Sequencer state.
  logic [0:0]                  r_state;
  logic [CW-1:0]               r_cnt;
  logic [DEPTH-1:0]            r_kill;      // b_id squashed on entry to RECOVER
  logic [1:0]                  r_br_task;
  logic [DEPTH-1:0]            r_rem_b_id;

  // Selection.
  logic [DEPTH-1:0]            w_mis_vld;
  logic [DEPTH-1:0]            w_sq_cand;
  logic [DEPTH-1:0]            w_clr_cand;
  logic [DEPTH-1:0]            w_sq_oh;
  logic [DEPTH-1:0]            w_clr_oh;
  logic                        w_run;
  logic                        w_sq_fire;
  logic                        w_clr_fire;
  logic [DEPTH-1:0]            w_kill;
  logic [DEPTH-1:0]            w_unmask;

  // Next slot state.
  logic [N-1:0]                w_arr_ok;
  logic [DEPTH-1:0]            w_taken;
  logic [DEPTH-1:0]            w_vld_n;
  logic [DEPTH-1:0]            w_mis_n;
  logic [DEPTH-1:0][DEPTH-1:0] w_mask_n;

  // A mispredicted slot may squash only if none of the branches it depends on is itself a pending mispredict.
  always_comb begin
    w_mis_vld  = r_vld & r_mis;
    w_clr_cand = r_vld & ~r_mis;
    w_sq_cand  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_sq_cand[k] = w_mis_vld[k] &&
                     ((r_mask[k] & w_mis_vld & ~(DEPTH'(1) << k)) == '0);
    end
  end

  // Lowest-index pick; only RUN issues, squashes win over clears.
  assign w_sq_oh    = w_sq_cand & (~w_sq_cand + DEPTH'(1));
  assign w_clr_oh   = w_clr_cand & (~w_clr_cand + DEPTH'(1));
  assign w_run      = (r_state == S_RUN);
  assign w_sq_fire  = w_run && (w_sq_cand != '0);
  assign w_clr_fire = w_run && (w_sq_cand == '0) && (w_clr_cand != '0);
  assign w_kill     = w_sq_fire ? w_sq_oh : (w_run ? '0 : r_kill);
  assign w_unmask   = w_clr_fire ? w_clr_oh : '0;

  // Arrivals that are younger than (or are) the branch being squashed are discarded.
  always_comb begin
    w_arr_ok = '0;
    for (int n = 0; n < N; n++) begin
      w_arr_ok[n] = io_sched.res_valid[n] &&
                    !((w_kill != '0) &&
                      (((io_sched.res_b_mask[n] & w_kill) != '0) ||
                       (io_sched.res_b_id[n] == w_kill)));
    end
  end

  // Apply the issued task to the slots, then capture surviving arrivals into free slots.
  always_comb begin
    w_vld_n  = r_vld;
    w_mis_n  = r_mis;
    w_mask_n = r_mask;
    w_taken  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_sq_fire && (w_sq_oh[k] || ((r_mask[k] & w_sq_oh) != '0))) begin
        w_vld_n[k] = 1'b0;
      end
      if (w_clr_fire) begin
        if (w_clr_oh[k]) begin
          w_vld_n[k] = 1'b0;
        end
        w_mask_n[k] = r_mask[k] & ~w_clr_oh;
      end
    end
    // A slot already holding a resolution keeps it; the duplicate is dropped.
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_arr_ok[n] && io_sched.res_b_id[n][k] && !r_vld[k] && !w_taken[k]) begin
          w_vld_n[k]  = 1'b1;
          w_mis_n[k]  = io_sched.res_mispred[n];
          w_mask_n[k] = io_sched.res_b_mask[n] & ~w_unmask;
          w_taken[k]  = 1'b1;
        end
      end
    end
  end

  // Slot registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_vld  <= '0;
      r_mis  <= '0;
      r_mask <= '0;
    end else begin
      r_vld  <= w_vld_n;
      r_mis  <= w_mis_n;
      r_mask <= w_mask_n;
    end
  end

  // RUN/RECOVER sequencing and the registered task output.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_kill     <= '0;
      r_br_task  <= BR_NOTHING;
      r_rem_b_id <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_sq_fire) begin
            r_state    <= S_RECOVER;
            r_cnt      <= CW'(RECOVER_CYC);
            r_kill     <= w_sq_oh;
            r_br_task  <= BR_SQUASH;
            r_rem_b_id <= w_sq_oh;
          end else if (w_clr_fire) begin
            r_br_task  <= BR_CLEAR;
            r_rem_b_id <= w_clr_oh;
          end else begin
            r_br_task  <= BR_NOTHING;
            r_rem_b_id <= '0;
          end
        end
        S_RECOVER: begin
          r_br_task  <= BR_NOTHING;
          r_rem_b_id <= '0;
          if (r_cnt <= CW'(1)) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_kill  <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_br_task  <= BR_NOTHING;
          r_rem_b_id <= '0;
        end
      endcase
    end
  end

  assign io_sched.br_task    = r_br_task;
  assign io_sched.rem_b_id   = r_rem_b_id;
  assign io_sched.recovering = (r_state == S_RECOVER);
  assign io_sched.pending    = r_vld;

`ifdef BR_TASK_SCHED_PERF_EN
  logic [31:0] r_perf_sq;
  logic [31:0] r_perf_clr;
  logic [31:0] r_perf_rec;

  // Saturating event counters: squashes, clears, cycles spent recovering.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_sq  <= '0;
      r_perf_clr <= '0;
      r_perf_rec <= '0;
    end else begin
      if (w_sq_fire && (r_perf_sq != '1)) begin
        r_perf_sq <= r_perf_sq + 32'd1;
      end
      if (w_clr_fire && (r_perf_clr != '1)) begin
        r_perf_clr <= r_perf_clr + 32'd1;
      end
      if (!w_run && (r_perf_rec != '1)) begin
        r_perf_rec <= r_perf_rec + 32'd1;
      end
    end
  end

  assign o_perf_squash_cnt  = r_perf_sq;
  assign o_perf_clear_cnt   = r_perf_clr;
  assign o_perf_recover_cyc = r_perf_rec;
`endif

`ifdef DEBUG
  // A resolution for a b_id that is still buffered indicates an upstream protocol error.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int n = 0; n < N; n++) begin
        for (int k = 0; k < DEPTH; k++) begin
          assert (!(w_arr_ok[n] && io_sched.res_b_id[n][k] && r_vld[k]))
            else $error("br_task_sched: duplicate resolution for slot %0d dropped", k);
        end
      end
    end
  end
`endif

endmodule
